dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port data memory between two requesters: the CPU MEM stage (port C, high priority) and the DMA/debug loader (port D, low priority). Each cycle it grants at most one requester and drives the memory's address/writeData/memWrite/memRead pins from that requester. A starvation counter guarantees D forward progress. Wrapping per-port transaction counters record the number of completed accesses. The block sits between the pipeline's MEM stage, the loader and the data memory.

## Interface
- DEPTH, 128: memory depth in words. Addresses are word indices.
- STARVE_LIMIT, 4: consecutive denied cycles of D before D takes priority, range 1..15.
- CLK  in  1  clock. Memory writes occur on its falling edge.
- RESET_N  in  1  asynchronous, active-low reset.
- c_req, c_we  in  1 each  CPU request and write-enable.
- c_addr, c_wdata  in  32 each  CPU word address and write data.
- c_ack  out  1  CPU granted this cycle.
- c_rdata  out  32  CPU read data, valid while c_ack is high.
- c_stall  out  1  c_req & ~c_ack.
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata: same as the CPU port, for the loader.
- err  out  1  granted access has an out-of-range address.
- mem_address, mem_writeData  out  32 each  to the memory.
- mem_memWrite, mem_memRead  out  1 each  to the memory.
- mem_readData  in  32  combinational read data from the memory.
- c_count, d_count  out  16 each  completed accesses per port, wrapping.

## Operation
- Arbitration is combinational within the request cycle; the arbiter holds registered priority state.
- The FSM has two states, C_PRI and D_PRI. The reset state is C_PRI.
  - In C_PRI: if c_req is high, grant C; otherwise, if d_req is high, grant D.
  - In D_PRI: if d_req is high, grant D; otherwise, if c_req is high, grant C.
- Starvation counter, 4 bits:
  - Cleared on any D grant.
  - Incremented when d_req is high and D is not granted.
  - Saturates at STARVE_LIMIT.
  - When the counter reaches STARVE_LIMIT, the next state is D_PRI.
  - After a D grant, the next state is C_PRI.
- Granted port drives the memory:
  - mem_address is the port's address.
  - mem_writeData is the port's write data.
  - mem_memWrite is the port's write-enable.
  - mem_memRead is the inverse of the port's write-enable.
- With no grant, all memory outputs are 0.
- Read data routing:
  - rdata for the acked port is mem_readData for reads, and 0 for writes.
  - rdata for the non-acked port is 0.
- Out of range means addr ≥ DEPTH.
  - The access is still acked.
  - err is asserted for the cycle.
  - mem_memWrite and mem_memRead are forced to 0.
  - rdata is 0.
  - The port counter still increments.
- Requests are levels. A requester holding req high across several cycles issues one access per acked cycle. It updates or drops req after the rising edge that ends an ack cycle. Back-to-back accesses at 1 per cycle are supported.
- Counters increment at the rising edge ending each ack cycle. They wrap from 0xFFFF to 0.

## Timing
- Latency is zero cycles. ack and rdata are valid in the same cycle as the granted request.
- Write commit happens at the falling edge inside the ack cycle. Request signals must be stable from the preceding rising edge through that falling edge.
- Reset values:
  - State is C_PRI.
  - Starvation counter, c_count and d_count are 0.
  - While RESET_N is low, c_ack, d_ack, err, mem_memWrite and mem_memRead are forced to 0, and all data outputs are 0.
- Reset asserted mid-cycle drops mem_memWrite immediately, so no write occurs at the following falling edge.
- Simultaneous c_req and d_req: the current state decides the winner. The loser's ack stays 0, and it must hold its request.
- c_ack and d_ack are never both high.

## Test plan
- Reset: assert RESET_N=0 with c_req=d_req=1. Required: both acks, mem_memWrite and the counters are 0. After release, C is granted first.
- CPU write then read:
  - Cycle 1: c_we=1, addr 5, data 0xDEADBEEF. Required: c_ack=1, mem_memWrite=1, c_stall=0.
  - Cycle 2: c_we=0, addr 5. Required: c_rdata=0xDEADBEEF, c_count=2 afterwards.
- Starvation with STARVE_LIMIT=4: hold c_req and d_req continuously. Required: C is granted cycles 1-4, D in cycle 5, C in cycles 6-9, D in cycle 10. d_stall-equivalent denials never exceed 4.
- D only: d_req held for 3 cycles with c_req=0. Required: d_ack=1 for all 3 cycles and d_count=3.
- Out of range: c_addr=128 with a write. Required: c_ack=1, err=1, mem_memWrite=0, memory word 0 unchanged, c_count increments.
- Reset during a write: drop RESET_N while the CPU write to addr 7 is granted, before the falling edge. Required: mem_memWrite=0 immediately and memory[7] retains its old value.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Shared data-memory bus: CPU port, loader port and memory pins.
// The arbiter takes the slave view; requesters and memory take master.
interface dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_ack;
  logic [31:0] c_rdata;
  logic        c_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;
  logic [15:0] c_count;
  logic [15:0] d_count;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_readData,
    output c_ack, c_rdata, c_stall,
    output d_ack, d_rdata, err,
    output mem_address, mem_writeData,
    output mem_memWrite, mem_memRead,
    output c_count, d_count
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_readData,
    input  c_ack, c_rdata, c_stall,
    input  d_ack, d_rdata, err,
    input  mem_address, mem_writeData,
    input  mem_memWrite, mem_memRead,
    input  c_count, d_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU high priority, loader protected
// from starvation, zero-latency grant, wrapping per-port access counters.
module dmem_arbiter #(
  parameter int DEPTH        = 128,
  parameter int STARVE_LIMIT = 4
) (
  input logic            CLK,
  input logic            RESET_N,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {C_PRI, D_PRI} state_e;

  localparam logic [3:0]  LIM     = 4'(STARVE_LIMIT);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] c_cnt_q, d_cnt_q;

  logic        gnt_c, gnt_d, gnt;
  logic        sel_we, oor;
  logic [31:0] sel_addr, sel_wdata, rd;

  // Grants are gated by reset so an async reset kills writes at once
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (RESET_N) begin
      if (state_q == D_PRI) begin
        gnt_d = bus.d_req;
        gnt_c = bus.c_req & ~bus.d_req;
      end else begin
        gnt_c = bus.c_req;
        gnt_d = bus.d_req & ~bus.c_req;
      end
    end
  end

  assign gnt       = gnt_c | gnt_d;
  assign sel_addr  = gnt_d ? bus.d_addr  : bus.c_addr;
  assign sel_wdata = gnt_d ? bus.d_wdata : bus.c_wdata;
  assign sel_we    = gnt_d ? bus.d_we    : bus.c_we;
  assign oor       = sel_addr >= DEPTH_W;

  assign bus.c_ack         = gnt_c;
  assign bus.d_ack         = gnt_d;
  assign bus.c_stall       = bus.c_req & ~gnt_c;
  assign bus.err           = gnt & oor;
  assign bus.mem_address   = gnt ? sel_addr  : '0;
  assign bus.mem_writeData = gnt ? sel_wdata : '0;
  assign bus.mem_memWrite  = gnt & ~oor & sel_we;
  assign bus.mem_memRead   = gnt & ~oor & ~sel_we;

  assign rd          = bus.mem_memRead ? bus.mem_readData : '0;
  assign bus.c_rdata = gnt_c ? rd : '0;
  assign bus.d_rdata = gnt_d ? rd : '0;
  assign bus.c_count = c_cnt_q;
  assign bus.d_count = d_cnt_q;

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (gnt_d) begin
      starve_d = '0;
      state_d  = C_PRI;
    end else begin
      if (bus.d_req && starve_q < LIM)
        starve_d = starve_q + 4'd1;
      if (starve_d == LIM)
        state_d = D_PRI;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= C_PRI;
      starve_q <= '0;
      c_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (gnt_c) c_cnt_q <= c_cnt_q + 16'd1;
      if (gnt_d) d_cnt_q <= d_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver queues expected responses,
// monitor pops and compares each cycle, memory modelled on falling edge.
module tb_dmem_arbiter;

  typedef struct {
    int          id;
    logic        ca, da, er, mw, mr, cs;
    logic [31:0] crd, drd;
    logic [15:0] cc, dc;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(128), .STARVE_LIMIT(4)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:127];
  always @(negedge CLK)
    if (bus.mem_memWrite)
      mem[bus.mem_address[6:0]] <= bus.mem_writeData;
  assign bus.mem_readData = (bus.mem_address < 32'd128) ?
                            mem[bus.mem_address[6:0]] : 32'h0;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int vid = 0;
  int ecc = 0;
  int edc = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d got %h exp %h", nm, id, act, exp);
    end
  endtask

  task automatic push(input bit eca, eda, eer, emw, emr,
                      input logic [31:0] ecrd, edrd);
    exp_t e;
    e.id = vid;
    e.ca = eca; e.da = eda; e.er = eer;
    e.mw = emw; e.mr = emr;
    e.cs = bus.c_req & ~eca;
    e.crd = ecrd; e.drd = edrd;
    e.cc = 16'(ecc); e.dc = 16'(edc);
    q.push_back(e);
    vid++;
  endtask

  task automatic cyc(input bit rst,
                     input bit cr, cw, input logic [31:0] ca, cd,
                     input bit dr, dw, input logic [31:0] da, dd,
                     input bit eca, eda, eer, emw, emr,
                     input logic [31:0] ecrd, edrd);
    @(posedge CLK);
    #1;
    RESET_N = rst;
    bus.c_req = cr; bus.c_we = cw;
    bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw;
    bus.d_addr = da; bus.d_wdata = dd;
    if (!rst) begin ecc = 0; edc = 0; end
    push(eca, eda, eer, emw, emr, ecrd, edrd);
    if (rst && eca) ecc++;
    if (rst && eda) edc++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("c_ack",   e.id, 32'(bus.c_ack),   32'(e.ca));
        chk("d_ack",   e.id, 32'(bus.d_ack),   32'(e.da));
        chk("err",     e.id, 32'(bus.err),     32'(e.er));
        chk("memWr",   e.id, 32'(bus.mem_memWrite), 32'(e.mw));
        chk("memRd",   e.id, 32'(bus.mem_memRead),  32'(e.mr));
        chk("c_stall", e.id, 32'(bus.c_stall), 32'(e.cs));
        chk("c_rdata", e.id, bus.c_rdata,      e.crd);
        chk("d_rdata", e.id, bus.d_rdata,      e.drd);
        chk("c_count", e.id, 32'(bus.c_count), 32'(e.cc));
        chk("d_count", e.id, 32'(bus.d_count), 32'(e.dc));
      end
    end
  end

  initial begin
    bus.c_req = 1'b1; bus.c_we = 1'b1;
    bus.c_addr = 32'd5; bus.c_wdata = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    bus.d_addr = 32'd20; bus.d_wdata = 32'h0;

    // reset with both requesting
    cyc(0, 1,1,32'd5,32'h1, 1,0,32'd20,32'h0, 0,0,0,0,0, 0,0);
    // release: C wins first, write 5
    cyc(1, 1,1,32'd5,32'hDEADBEEF, 1,0,32'd20,32'h0,
        1,0,0,1,0, 0,0);
    cyc(1, 1,0,32'd5,32'h0, 0,0,32'd0,32'h0,
        1,0,0,0,1, 32'hDEADBEEF,0);
    // D only, three cycles
    cyc(1, 0,0,32'd0,32'h0, 1,1,32'd10,32'h11, 0,1,0,1,0, 0,0);
    cyc(1, 0,0,32'd0,32'h0, 1,1,32'd11,32'h22, 0,1,0,1,0, 0,0);
    cyc(1, 0,0,32'd0,32'h0, 1,0,32'd10,32'h0,
        0,1,0,0,1, 0,32'h11);
    cyc(1, 1,1,32'd0,32'hCAFE0000, 0,0,32'd0,32'h0,
        1,0,0,1,0, 0,0);
    cyc(1, 1,1,32'd7,32'h77777777, 0,0,32'd0,32'h0,
        1,0,0,1,0, 0,0);
    cyc(1, 0,0,32'd0,32'h0, 0,0,32'd0,32'h0, 0,0,0,0,0, 0,0);
    // starvation: D wins cycles 5 and 10
    for (int i = 1; i <= 10; i++) begin
      if (i == 5 || i == 10)
        cyc(1, 1,0,32'd5,32'h0, 1,0,32'd11,32'h0,
            0,1,0,0,1, 0,32'h22);
      else
        cyc(1, 1,0,32'd5,32'h0, 1,0,32'd11,32'h0,
            1,0,0,0,1, 32'hDEADBEEF,0);
    end
    // out of range write and read
    cyc(1, 1,1,32'd128,32'h00000BAD, 0,0,32'd0,32'h0,
        1,0,1,0,0, 0,0);
    cyc(1, 1,0,32'd0,32'h0, 0,0,32'd0,32'h0,
        1,0,0,0,1, 32'hCAFE0000,0);
    cyc(1, 1,0,32'd200,32'h0, 0,0,32'd0,32'h0,
        1,0,1,0,0, 0,0);

    // reset asserted inside a granted write to 7
    @(posedge CLK);
    #1;
    bus.c_req = 1'b1; bus.c_we = 1'b1;
    bus.c_addr = 32'd7; bus.c_wdata = 32'h12345678;
    bus.d_req = 1'b0;
    #1;
    RESET_N = 1'b0;
    ecc = 0; edc = 0;
    push(0,0,0,0,0, 0,0);
    @(negedge CLK);
    #1;
    chk("mem7_kept", vid, mem[7], 32'h77777777);

    cyc(1, 1,0,32'd7,32'h0, 0,0,32'd0,32'h0,
        1,0,0,0,1, 32'h77777777,0);
    cyc(1, 0,0,32'd0,32'h0, 0,0,32'd0,32'h0, 0,0,0,0,0, 0,0);

    repeat (3) @(posedge CLK);
    #4;
    chk("q_drained", vid, 32'(q.size()), 32'd0);
    chk("mem0_kept", vid, mem[0], 32'hCAFE0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
